// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array controller: FSM states, default
// geometry and helpers for locating a lane inside a packed buffer word.
package tpu_pkg;

    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_ADDR_W = 16;

    localparam int DIM_W = 8;
    localparam int TMR_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Lane 0 sits at the MSB end of a packed word.
    function automatic int lane_lsb(input int lane, input int lanes, input int width);
        return (lanes - 1 - lane) * width;
    endfunction

endpackage

// File: rtl/tpu_pe.sv
// One multiply-accumulate cell of the systolic array; forwards its left
// operand to the right and its top operand downward one cycle later.
module tpu_pe
    import tpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    localparam int PROD_W = 2 * DATA_W + 2;

    logic signed [DATA_W:0]   a_ext;
    logic signed [DATA_W:0]   b_ext;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_acc;

    // One extra operand bit lets a single signed multiplier serve both modes.
    assign a_ext    = {signed_mode & a_in[DATA_W-1], a_in};
    assign b_ext    = {signed_mode & b_in[DATA_W-1], b_in};
    assign prod     = a_ext * b_ext;
    assign prod_acc = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_acc;
        end
    end

endmodule

// File: rtl/tpu_array_ctrl.sv
// Tiled matrix-multiply controller: streams A/B tiles through a ROWSxCOLS
// output-stationary systolic array and writes each C tile back row by row.
//
// state | meaning
// IDLE  | waiting for in_valid
// CLEAR | zero array, issue k=0 reads
// FEED  | K cycles of operand streaming
// DRAIN | flush skewed operands with zeros
// WRITE | one C row per cycle
// DONE  | done pulse, back to IDLE
module tpu_array_ctrl
    import tpu_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DIM_W-1:0]       K,
    input  logic [DIM_W-1:0]       M,
    input  logic [DIM_W-1:0]       N,
    input  logic                   signed_mode,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      A_index,
    output logic [ADDR_W-1:0]      B_index,
    input  logic [ROWS*DATA_W-1:0] A_data_out,
    input  logic [COLS*DATA_W-1:0] B_data_out,
    output logic                   C_wr_en,
    output logic [ADDR_W-1:0]      C_index,
    output logic [COLS*ACC_W-1:0]  C_data_in
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [DIM_W-1:0]   k_lat;
    logic [DIM_W-1:0]   m_lat;
    logic [DIM_W-1:0]   m_rem;
    logic [DIM_W-1:0]   n_rem;
    logic               sgn_lat;
    logic               zero_job;
    logic [ADDR_W-1:0]  a_base;
    logic [ADDR_W-1:0]  b_base;
    logic [ADDR_W-1:0]  c_nt_base;
    logic [ADDR_W-1:0]  c_tile;
    logic [ROW_W-1:0]   wr_row;

    logic               pe_clr;
    logic               pe_en;
    logic               feeding;
    logic               last_mt;
    logic               last_nt;
    logic [DIM_W-1:0]   rows_this;

    logic [DATA_W-1:0]      a_h [ROWS][COLS];
    logic [DATA_W-1:0]      b_v [ROWS][COLS];
    logic [ACC_W-1:0]       acc [ROWS][COLS];
    logic [COLS*ACC_W-1:0]  row_data [ROWS];

    assign pe_clr    = (state == ST_CLEAR);
    assign pe_en     = (state == ST_FEED) || (state == ST_DRAIN);
    assign feeding   = (state == ST_FEED);
    assign last_mt   = (m_rem <= DIM_W'(ROWS));
    assign last_nt   = (n_rem <= DIM_W'(COLS));
    assign rows_this = last_mt ? m_rem : DIM_W'(ROWS);

    // Edge lanes outside the matrix, and everything during DRAIN, enter as zero.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_edge
        logic [DATA_W-1:0] lane_in;
        assign lane_in = (feeding && (DIM_W'(r) < m_rem))
                       ? A_data_out[lane_lsb(r, ROWS, DATA_W) +: DATA_W] : '0;
        if (r == 0) begin : g_direct
            assign a_h[0][0] = lane_in;
        end else begin : g_skew
            logic [DATA_W-1:0] sr [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else if (pe_clr) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else if (pe_en) begin
                    sr[0] <= lane_in;
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_h[r][0] = sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_edge
        logic [DATA_W-1:0] lane_in;
        assign lane_in = (feeding && (DIM_W'(c) < n_rem))
                       ? B_data_out[lane_lsb(c, COLS, DATA_W) +: DATA_W] : '0;
        if (c == 0) begin : g_direct
            assign b_v[0][0] = lane_in;
        end else begin : g_skew
            logic [DATA_W-1:0] sr [c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else if (pe_clr) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else if (pe_en) begin
                    sr[0] <= lane_in;
                    for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
                end
            end
            assign b_v[0][c] = sr[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [DATA_W-1:0] a_fwd;
            logic [DATA_W-1:0] b_fwd;

            tpu_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk         (clk),
                .rst_n       (rst_n),
                .clr         (pe_clr),
                .en          (pe_en),
                .signed_mode (sgn_lat),
                .a_in        (a_h[r][c]),
                .b_in        (b_v[r][c]),
                .a_out       (a_fwd),
                .b_out       (b_fwd),
                .acc         (acc[r][c])
            );

            if (c < COLS - 1) begin : g_a_next
                assign a_h[r][c+1] = a_fwd;
            end else begin : g_a_end
                logic [DATA_W-1:0] a_unused;
                assign a_unused = a_fwd;
            end
            if (r < ROWS - 1) begin : g_b_next
                assign b_v[r+1][c] = b_fwd;
            end else begin : g_b_end
                logic [DATA_W-1:0] b_unused;
                assign b_unused = b_fwd;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_data[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                row_data[r][(COLS-1-c)*ACC_W +: ACC_W] = acc[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            k_lat     <= '0;
            m_lat     <= '0;
            m_rem     <= '0;
            n_rem     <= '0;
            sgn_lat   <= 1'b0;
            zero_job  <= 1'b0;
            a_base    <= '0;
            b_base    <= '0;
            c_nt_base <= '0;
            c_tile    <= '0;
            wr_row    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            A_index   <= '0;
            B_index   <= '0;
            C_wr_en   <= 1'b0;
            C_index   <= '0;
            C_data_in <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        k_lat     <= K;
                        m_lat     <= M;
                        m_rem     <= M;
                        n_rem     <= N;
                        sgn_lat   <= signed_mode;
                        zero_job  <= (K == '0) || (M == '0) || (N == '0);
                        a_base    <= '0;
                        b_base    <= '0;
                        c_nt_base <= '0;
                        c_tile    <= '0;
                        A_index   <= '0;
                        B_index   <= '0;
                        busy      <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // An empty job spends its second busy cycle in a write-less WRITE.
                    if (zero_job) begin
                        tmr   <= '0;
                        state <= ST_WRITE;
                    end else begin
                        tmr     <= TMR_W'(k_lat) - TMR_W'(1);
                        A_index <= A_index + ADDR_W'(1);
                        B_index <= B_index + ADDR_W'(1);
                        state   <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (tmr == '0) begin
                        tmr   <= TMR_W'(ROWS + COLS - 2);
                        state <= ST_DRAIN;
                    end else begin
                        tmr     <= tmr - TMR_W'(1);
                        A_index <= A_index + ADDR_W'(1);
                        B_index <= B_index + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (tmr == '0) begin
                        tmr       <= TMR_W'(rows_this) - TMR_W'(1);
                        wr_row    <= ROW_W'(1);
                        C_wr_en   <= 1'b1;
                        C_index   <= c_tile;
                        C_data_in <= row_data[0];
                        state     <= ST_WRITE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (tmr == '0) begin
                        C_wr_en <= 1'b0;
                        if (zero_job || (last_mt && last_nt)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (last_mt) begin
                            m_rem     <= m_lat;
                            n_rem     <= n_rem - DIM_W'(COLS);
                            a_base    <= '0;
                            b_base    <= b_base + ADDR_W'(k_lat);
                            c_nt_base <= c_nt_base + ADDR_W'(m_lat);
                            c_tile    <= c_nt_base + ADDR_W'(m_lat);
                            A_index   <= '0;
                            B_index   <= b_base + ADDR_W'(k_lat);
                            state     <= ST_CLEAR;
                        end else begin
                            m_rem   <= m_rem - DIM_W'(ROWS);
                            a_base  <= a_base + ADDR_W'(k_lat);
                            c_tile  <= c_tile + ADDR_W'(ROWS);
                            A_index <= a_base + ADDR_W'(k_lat);
                            B_index <= b_base;
                            state   <= ST_CLEAR;
                        end
                    end else begin
                        tmr       <= tmr - TMR_W'(1);
                        wr_row    <= wr_row + ROW_W'(1);
                        C_index   <= C_index + ADDR_W'(1);
                        C_data_in <= row_data[wr_row];
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_array_ctrl.sv
// Self-checking bench for tpu_array_ctrl: a matrix-level golden model builds
// the expected C write stream, and a monitor compares every write against it.
module tb_tpu_array_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int ADW  = 16;
    localparam int MEM  = 1024;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [7:0]           K, M, N;
    logic                 signed_mode;
    logic                 busy, done;
    logic [ADW-1:0]       A_index, B_index, C_index;
    logic [ROWS*DW-1:0]   A_data_out;
    logic [COLS*DW-1:0]   B_data_out;
    logic                 C_wr_en;
    logic [COLS*AW-1:0]   C_data_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tpu_array_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .ADDR_W(ADW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .K(K), .M(M), .N(N), .signed_mode(signed_mode),
        .busy(busy), .done(done),
        .A_index(A_index), .B_index(B_index),
        .A_data_out(A_data_out), .B_data_out(B_data_out),
        .C_wr_en(C_wr_en), .C_index(C_index), .C_data_in(C_data_in)
    );

    logic [ROWS*DW-1:0] amem [MEM];
    logic [COLS*DW-1:0] bmem [MEM];

    always @(posedge clk) begin
        A_data_out <= (A_index < MEM) ? amem[A_index] : '0;
        B_data_out <= (B_index < MEM) ? bmem[B_index] : '0;
    end

    logic [7:0]  a_mat [8][256];
    logic [7:0]  b_mat [256][8];
    logic [31:0] c_mod [8][8];
    int          exp_busy;

    typedef struct {
        logic [ADW-1:0]     idx;
        logic [COLS*AW-1:0] dat;
    } wr_t;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int ext(input logic [7:0] v, input bit sgn);
        if (sgn) return int'($signed(v));
        return int'({24'd0, v});
    endfunction

    task automatic build_model(input int k, input int m, input int n, input bit sgn);
        logic [31:0] s;
        wr_t         w;
        int          mt_n, nt_n, rows, col;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                s = '0;
                if (i < m && j < n)
                    for (int kk = 0; kk < k; kk++)
                        s += 32'(ext(a_mat[i][kk], sgn) * ext(b_mat[kk][j], sgn));
                c_mod[i][j] = s;
            end
        end
        exp_q.delete();
        if (k == 0 || m == 0 || n == 0) begin
            exp_busy = 2;
            return;
        end
        mt_n = (m + ROWS - 1) / ROWS;
        nt_n = (n + COLS - 1) / COLS;
        exp_busy = 0;
        for (int nt = 0; nt < nt_n; nt++) begin
            for (int mt = 0; mt < mt_n; mt++) begin
                rows = (m - mt*ROWS < ROWS) ? m - mt*ROWS : ROWS;
                exp_busy += 1 + k + ROWS + COLS - 1 + rows;
                for (int r = 0; r < rows; r++) begin
                    w.idx = ADW'(nt*m + mt*ROWS + r);
                    w.dat = '0;
                    for (int c = 0; c < COLS; c++) begin
                        col = nt*COLS + c;
                        if (col < n) w.dat[(COLS-1-c)*AW +: AW] = c_mod[mt*ROWS + r][col];
                    end
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    // Lanes outside the matrix carry junk; the DUT must ignore it.
    task automatic load_mem(input int k, input int m, input int n);
        logic [ROWS*DW-1:0] aw;
        logic [COLS*DW-1:0] bw;
        int mt_n, nt_n, idx;
        for (int i = 0; i < MEM; i++) begin
            amem[i] = '0;
            bmem[i] = '0;
        end
        mt_n = (m + ROWS - 1) / ROWS;
        nt_n = (n + COLS - 1) / COLS;
        for (int kk = 0; kk < k; kk++) begin
            for (int mt = 0; mt < mt_n; mt++) begin
                for (int r = 0; r < ROWS; r++)
                    aw[(ROWS-1-r)*DW +: DW] = (mt*ROWS + r < m) ? a_mat[mt*ROWS + r][kk] : 8'($urandom);
                idx = mt*k + kk;
                amem[idx] = aw;
            end
            for (int nt = 0; nt < nt_n; nt++) begin
                for (int c = 0; c < COLS; c++)
                    bw[(COLS-1-c)*DW +: DW] = (nt*COLS + c < n) ? b_mat[kk][nt*COLS + c] : 8'($urandom);
                idx = nt*k + kk;
                bmem[idx] = bw;
            end
        end
    endtask

    task automatic fill(input int mode, input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 8; i++) begin
            for (int kk = 0; kk < 256; kk++) begin
                case (mode)
                    0: begin a_mat[i][kk] = (i == kk) ? 8'd1 : 8'd0; b_mat[kk][i] = (i == kk) ? 8'd1 : 8'd0; end
                    1: begin a_mat[i][kk] = av; b_mat[kk][i] = bv; end
                    default: begin a_mat[i][kk] = 8'($urandom); b_mat[kk][i] = 8'($urandom); end
                endcase
            end
        end
    endtask

    task automatic start_job(input int k, input int m, input int n, input bit sgn);
        build_model(k, m, n, sgn);
        load_mem(k, m, n);
        @(negedge clk);
        K = 8'(k); M = 8'(m); N = 8'(n); signed_mode = sgn; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        K = 8'd77; M = 8'd1; N = 8'd1; signed_mode = ~sgn;
        check("busy_rise", busy, 1'b1);
    endtask

    task automatic run_job(input int k, input int m, input int n, input bit sgn, input bit inject);
        int cnt;
        start_job(k, m, n, sgn);
        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            cnt++;
            if (inject && cnt == 3) begin
                in_valid = 1'b1; K = 8'd2; M = 8'd1; N = 8'd1; signed_mode = ~sgn;
            end
            if (inject && cnt == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        check("busy_cycles", 128'(cnt), 128'(exp_busy));
        check("done_pulse", done, 1'b1);
        @(negedge clk);
        check("done_low", done, 1'b0);
        check("writes_left", 128'(exp_q.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && C_wr_en === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: idx %0d data %h", C_index, C_data_in);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if (C_index !== w.idx || C_data_in !== w.dat || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL c_write: got idx %0d data %h busy %b expected idx %0d data %h",
                             C_index, C_data_in, busy, w.idx, w.dat);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst_n = 1'b0; in_valid = 1'b0; K = '0; M = '0; N = '0; signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_en", C_wr_en, 1'b0);
        check("rst_c_index", C_index, '0);
        check("rst_c_data", C_data_in, '0);
        check("rst_a_index", A_index, '0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(0, 8'd0, 8'd0);
        run_job(4, 4, 4, 1'b0, 1'b0);
        check("model_id_diag", c_mod[2][2], 32'd1);
        check("model_id_off", c_mod[1][2], 32'd0);
        check("model_id_busy", 128'(exp_busy), 128'd16);

        fill(1, 8'hFF, 8'h02);
        run_job(1, 4, 4, 1'b1, 1'b0);
        check("model_signed", c_mod[0][0], 32'hFFFFFFFE);
        run_job(1, 4, 4, 1'b0, 1'b0);
        check("model_unsigned", c_mod[3][1], 32'h000001FE);

        fill(2, 8'd0, 8'd0);
        run_job(3, 6, 5, 1'b0, 1'b0);
        check("model_tiled_busy", 128'(exp_busy), 128'd56);
        check("model_col5_zero", 128'(c_mod[5][5]), 128'd0);
        run_job(3, 6, 5, 1'b1, 1'b0);

        fill(1, 8'hFF, 8'hFF);
        run_job(255, 4, 4, 1'b0, 1'b0);
        check("model_k255", c_mod[3][2], 32'h00FD02FF);

        fill(0, 8'd0, 8'd0);
        run_job(4, 4, 4, 1'b0, 1'b1);

        run_job(0, 4, 4, 1'b0, 1'b0);
        run_job(3, 0, 4, 1'b0, 1'b0);
        run_job(3, 4, 0, 1'b1, 1'b0);

        // Abort a job in the middle of its WRITE phase.
        fill(2, 8'd0, 8'd0);
        start_job(4, 4, 4, 1'b0);
        cnt = 0;
        while (C_wr_en !== 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("reach_write", C_wr_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", C_wr_en, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy, 1'b0);
        check("post_rst_wr_en", C_wr_en, 1'b0);
        fill(0, 8'd0, 8'd0);
        run_job(4, 4, 4, 1'b0, 1'b0);
        fill(2, 8'd0, 8'd0);
        run_job(3, 6, 5, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_array_ctrl.md
TPU_ARRAY_CTRL -- requirements
Module: tpu_array_ctrl

Interface
REQ-001 Parameter ROWS, default 4: systolic array rows, i.e. output-tile height.
REQ-002 Parameter COLS, default 4: systolic array columns, i.e. output-tile width.
REQ-003 Parameter DATA_W, default 8: operand element width.
REQ-004 Parameter ACC_W, default 32: accumulator / C element width.
REQ-005 Parameter ADDR_W, default 16: buffer index width.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 in_valid  in  1  start pulse; K, M, N and signed_mode sampled on the same edge.
REQ-009 K, M, N  in  8 each  inner dimension, C rows, C cols.
REQ-010 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 busy  out  1  high from the cycle after accepted in_valid through the last C write.
REQ-012 done  out  1  one-cycle pulse after the final C write.
REQ-013 A_index / B_index  out  ADDR_W  read addresses; A_data_out / B_data_out  in  ROWS*DATA_W / COLS*DATA_W; read latency 1 cycle.
REQ-014 C_wr_en  out  1, C_index  out  ADDR_W, C_data_in  out  COLS*ACC_W  write port.

Function
REQ-015 Layout: A word mt*K+k holds A[mt*ROWS+r][k], lane r at the MSB end; B word nt*K+k holds B[k][nt*COLS+c], lane c at the MSB end; C word nt*M+m holds C[m][nt*COLS+c], lane c at the MSB end.
REQ-016 Tiling: MT=ceil(M/ROWS), NT=ceil(N/COLS); tiles processed in order nt outer, mt inner.
REQ-017 FSM: IDLE -> CLEAR -> FEED -> DRAIN -> WRITE -> (CLEAR of next tile | DONE) -> IDLE.
REQ-018 in_valid is accepted only in IDLE; in_valid asserted while busy is ignored and leaves latched operands unchanged.
REQ-019 CLEAR, 1 cycle: zero every PE accumulator and pipeline register; issue address k=0.
REQ-020 FEED, K cycles: address k increments each cycle; lane r of A enters row r delayed r cycles, lane c of B enters column c delayed c cycles.
REQ-021 DRAIN, ROWS+COLS-1 cycles: zeros are injected at the array edges; PEs keep accumulating.
REQ-022 Each PE computes acc += sext/zext(left)*sext/zext(top) per signed_mode; the product is 2*DATA_W bits, extended to ACC_W; accumulation wraps modulo 2^ACC_W.
REQ-023 WRITE, min(ROWS, M-mt*ROWS) cycles, one row per cycle: C_wr_en=1, C_index=nt*M+mt*ROWS+r, C_data_in = row r accumulators.
REQ-024 Partial tiles: A lanes beyond M and B lanes beyond N are treated as zero; rows >= M are never written; columns >= N are written as 0.
REQ-025 K=0, M=0 or N=0: no reads or writes; busy stays high for exactly 2 cycles, then done pulses.
REQ-026 Per-tile latency = 1+K+(ROWS+COLS-1)+rows_written cycles.
REQ-027 C_wr_en is low in every state except WRITE.

Reset
REQ-028 rst_n low: FSM to IDLE; busy, done and C_wr_en to 0; all indices, C_data_in, accumulators and latched operands to 0.
REQ-029 Reset asserted mid-operation aborts the job with no further writes; the first cycle after release is IDLE.

Structure
REQ-030 Shared package tpu_pkg holds the FSM state enum, default parameter constants, and lane-slice helper widths.
REQ-031 Single sub-module tpu_pe (one MAC cell with right/bottom forwarding, clear, enable and signed_mode), instantiated ROWS*COLS times via generate.

Verification
REQ-032 Default params, K=M=N=4, unsigned, A=B=identity -> C rows 0..3 = identity at C_index 0..3; done 1+4+7+4 = 16 cycles after busy rises.
REQ-033 signed_mode=1, K=1, M=N=4, all A=-1 (8'hFF), all B=2 -> every C element 32'hFFFFFFFE; with signed_mode=0 -> 32'h000001FE.
REQ-034 M=6, N=5, K=3, random data -> C matches the golden model; 2x2 tiles; rows 6,7 never written; column 5 of nt=1 equal to 0.
REQ-035 K=255, all operands 8'hFF unsigned -> each element 255*65025 = 16581375 = 32'h00FD02FF; no overflow.
REQ-036 in_valid pulsed mid-FEED with different K -> ignored, results unchanged; K=0 -> busy for 2 cycles, no C_wr_en.
REQ-037 rst_n asserted during WRITE -> C_wr_en low immediately, busy 0, FSM in IDLE; a new job runs correctly afterward.
